gate_share_arbiter: RTL
=======================

Name: gate_share_arbiter

Overview:
- Shares one GATE-style 2-input logic resource and its output flop (FF) among N_REQ requesters.
- Round-robin arbitration selects one requester and captures its operands. A LATENCY-cycle execution counter runs, then the registered result is presented on a valid/ready output.
- Sits above the GATE/FF leaf cells as the sequencing controller. A parent cell instantiates it where several sources contend for a single configured gate.

Parameters:
- N_REQ, 4, number of requesters; 2..8.
- ID_W, 2, width of requester index; must equal clog2(N_REQ).
- LATENCY, 2, execution cycles between grant and result-valid; 1..15.
- OP, 0, gate function: 0=AND, 1=OR, 2=XOR, 3=NAND.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  synchronous active-low reset.
- REQ  input  N_REQ  per-requester request, level; held until its GNT pulse.
- I0  input  N_REQ  operand A, bit k belongs to requester k.
- I1  input  N_REQ  operand B, bit k belongs to requester k.
- GNT  output  N_REQ  one-hot grant, 1-cycle pulse.
- BUSY  output  1  high in EXEC or RESP.
- O_VALID  output  1  result valid.
- O_READY  input  1  consumer accepts result.
- Y  output  1  registered gate result.
- O_ID  output  ID_W  index of the requester that owns Y.

Behaviour:
- Reset is synchronous; RST_N=0 sampled at a CLK edge resets the block. It clears:
  - state=IDLE, GNT=0, BUSY=0, O_VALID=0, Y=0, O_ID=0;
  - round-robin pointer PTR=0, counter CNT=0.
- Reset mid-operation aborts any pending result. No GNT is issued in the cycle reset deasserts.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If REQ!=0, choose the first set bit k searching PTR, PTR+1, ... modulo N_REQ.
  - Next edge: GNT[k]=1 for exactly one cycle. Latch a=I0[k], b=I1[k] and O_ID=k. Set CNT=LATENCY-1 and enter EXEC.
  - If REQ=0, stay in IDLE with GNT=0.
- EXEC:
  - CNT decrements each cycle.
  - When CNT==0: Y=OP(a,b), O_VALID=1, enter RESP.
  - Total latency is grant edge to O_VALID edge = LATENCY cycles.
- RESP:
  - Y and O_ID are held stable while O_VALID=1 && O_READY=0.
  - On O_VALID && O_READY: O_VALID=0, PTR=(O_ID+1) mod N_REQ, return to IDLE.
  - The next grant can be issued at the earliest on the following edge, so back-to-back ops are spaced LATENCY+2 cycles with O_READY tied high.
- REQ changes during EXEC/RESP are ignored. Operands are only sampled at the grant edge.
- A requester that drops REQ before its grant simply loses its turn. There is no queuing.
- Wrap-around: PTR increments modulo N_REQ. After requester N_REQ-1 is served, PTR=0.
- Starvation bound: every continuously asserted REQ is granted within N_REQ transactions.
- O_READY asserted while O_VALID=0 has no effect.
- Invalid parameters (ID_W mismatch, LATENCY=0) are rejected at elaboration with $error.

Optional Feature:
- Macro: GATE_SHARE_ARBITER_LOCK_EN.
- When defined, adds input LOCK (1 bit).
- If LOCK=1 at the O_VALID&&O_READY handshake:
  - PTR is not advanced;
  - the next IDLE cycle grants the same O_ID when its REQ is set. Otherwise normal search from PTR.
  - LOCK is ignored after 4 consecutive locked transactions (fairness cap, counter reset by any unlocked handshake).
- When undefined, there is no LOCK port and behaviour is pure round-robin.

Decomposition:
- Package gate_share_pkg holds:
  - state enum (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - OP encodings (OP_AND, OP_OR, OP_XOR, OP_NAND);
  - the gate_op(op,a,b) function.
- One sub-module: rr_pick (combinational priority search from PTR, outputs one-hot and index), reused by other shared-resource arbiters.

Test Plan:
- Reset: RST_N=0 for 2 cycles with REQ=4'b1111 -> GNT=0, O_VALID=0, Y=0; first GNT=4'b0001 one edge after RST_N=1.
- Single op, OP=2 (XOR), LATENCY=2, REQ=4'b0100, I0[2]=1, I1[2]=0 -> GNT=4'b0100 pulse; O_VALID rises 2 cycles later with Y=1, O_ID=2.
- Fairness: REQ=4'b1111 held, O_READY=1 -> grant order 0,1,2,3,0; each GNT one cycle wide; spacing LATENCY+2=4 cycles.
- Backpressure: O_READY=0 for 5 cycles in RESP -> Y, O_ID, O_VALID stable; no GNT; accept on cycle 6, then next grant.
- Mid-op reset: RST_N=0 in EXEC -> O_VALID never asserts, PTR=0 afterwards.
- LOCK_EN build: LOCK=1, REQ=4'b0011 -> requester 0 granted 4 times, then requester 1.

Source files
------------

// File: rtl/gate_share_arbiter_pkg.sv
// gate_share_pkg: shared types and helpers for the gate-share arbiter.
//   state_e   : sequencing FSM states (IDLE, EXEC, RESP)
//   OP_*      : gate function encodings
//   CNT_W     : width of the execution latency counter (LATENCY up to 15)
//   LOCK_CAP  : longest run of back-to-back transactions one requester may
//               hold through LOCK (only used when the LOCK feature is built)
//   gate_op() : the shared 2-input logic resource
package gate_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  localparam int         CNT_W    = 4;
  localparam logic [2:0] LOCK_CAP = 3'd4;

  // Evaluate the configured 2-input gate.
  function automatic logic gate_op(input logic [1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_share_arbiter_if.sv
// gate_share_arbiter_if: request/result bundle between requesters, consumer
// and the gate-share arbiter.
//   req     : per-requester level request          (requesters -> arbiter)
//   i0, i1  : per-requester operands, bit k = req k (requesters -> arbiter)
//   gnt     : one-hot, one-cycle grant pulse        (arbiter -> requesters)
//   busy    : arbiter executing or presenting       (arbiter -> requesters)
//   o_valid : result valid                          (arbiter -> consumer)
//   o_ready : consumer accepts result               (consumer -> arbiter)
//   y       : registered gate result                (arbiter -> consumer)
//   o_id    : owner index of y                      (arbiter -> consumer)
// Modports: slave = arbiter side, master = requester/consumer side.
interface gate_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] i0;
  logic [N_REQ-1:0] i1;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic             o_valid;
  logic             o_ready;
  logic             y;
  logic [ID_W-1:0]  o_id;

  modport slave (
    input  req, i0, i1, o_ready,
    output gnt, busy, o_valid, y, o_id
  );

  modport master (
    output req, i0, i1, o_ready,
    input  gnt, busy, o_valid, y, o_id
  );

endinterface

// File: rtl/gate_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority search.
// Scans req starting at index ptr and wrapping modulo N_REQ; reports the first
// set bit as a one-hot vector and as an index. Reusable by any shared-resource
// arbiter that keeps its own rotating pointer.
//   req    : request vector
//   ptr    : highest-priority index this cycle
//   onehot : winner, one-hot (all zero when no request)
//   idx    : winner index (zero when no request)
//   any    : at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // First-set search from ptr, wrapping around the request vector.
  always_comb begin
    logic [ID_W-1:0] j_s;
    onehot = {N_REQ{1'b0}};
    idx    = {ID_W{1'b0}};
    any    = 1'b0;
    j_s    = {ID_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      j_s = ID_W'((int'(ptr) + i) % N_REQ);
      if (!any && req[j_s]) begin
        any         = 1'b1;
        onehot[j_s] = 1'b1;
        idx         = j_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/gate_share_arbiter.sv
// gate_share_arbiter: shares one configured 2-input gate and its result flop
// among N_REQ requesters. A round-robin pick grants one requester, its operands
// are captured at the grant edge, a LATENCY-cycle counter runs, and the
// registered result is then offered on a valid/ready output.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   lock  : (only with GATE_SHARE_ARBITER_LOCK_EN) keep priority on the
//           current owner at the result handshake, capped at LOCK_CAP runs
//   bus   : gate_share_arbiter_if.slave (req/i0/i1/gnt/busy/o_valid/o_ready/y/o_id)
// Configuration macro: GATE_SHARE_ARBITER_LOCK_EN (undefined = pure round-robin).
module gate_share_arbiter
  import gate_share_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int LATENCY = 2,
  parameter int OP      = 0
) (
  input  logic clk,
  input  logic rst_n,
`ifdef GATE_SHARE_ARBITER_LOCK_EN
  input  logic lock,
`endif
  gate_share_arbiter_if.slave bus
);

  localparam logic [1:0]       OP_SEL   = 2'(OP);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ - 1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  generate
    if (ID_W != $clog2(N_REQ)) begin : g_bad_id_w
      $error("gate_share_arbiter: ID_W must equal clog2(N_REQ)");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("gate_share_arbiter: N_REQ must be in 2..8");
    end
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("gate_share_arbiter: LATENCY must be in 1..15");
    end
    if (OP < 0 || OP > 3) begin : g_bad_op
      $error("gate_share_arbiter: OP must be in 0..3");
    end
  endgenerate

  state_e           state_r;
  state_e           state_nxt_s;
  logic [ID_W-1:0]  ptr_r;
  logic [ID_W-1:0]  ptr_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             a_r;
  logic             a_nxt_s;
  logic             b_r;
  logic             b_nxt_s;
  logic [N_REQ-1:0] gnt_r;
  logic [N_REQ-1:0] gnt_nxt_s;
  logic             busy_r;
  logic             o_valid_r;
  logic             o_valid_nxt_s;
  logic             y_r;
  logic             y_nxt_s;
  logic [ID_W-1:0]  o_id_r;
  logic [ID_W-1:0]  o_id_nxt_s;

  logic [N_REQ-1:0] pick_onehot_s;
  logic [ID_W-1:0]  pick_idx_s;
  logic             pick_any_s;
  logic [N_REQ-1:0] sel_onehot_s;
  logic [ID_W-1:0]  sel_idx_s;
  logic             sel_any_s;
  logic             hs_s;
  logic             lock_honor_s;

  assign hs_s = o_valid_r & bus.o_ready;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

`ifdef GATE_SHARE_ARBITER_LOCK_EN
  // locked_r is a one-shot: it only biases the first IDLE cycle after a
  // locked handshake. lock_run_r counts consecutive honoured locks.
  logic       locked_r;
  logic [2:0] lock_run_r;
  logic       hold_s;

  assign hold_s       = locked_r & bus.req[o_id_r];
  assign lock_honor_s = lock & (lock_run_r < (LOCK_CAP - 3'd1));

  // Lock bookkeeping: arm on honoured handshake, drop after one IDLE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked_r   <= 1'b0;
      lock_run_r <= 3'd0;
    end else begin
      if (hs_s) begin
        locked_r   <= lock_honor_s;
        lock_run_r <= lock_honor_s ? (lock_run_r + 3'd1) : 3'd0;
      end else if (state_r == IDLE) begin
        locked_r <= 1'b0;
      end else begin
        locked_r <= locked_r;
      end
    end
  end

  // Winner selection: the locked owner first, otherwise round-robin.
  always_comb begin
    sel_any_s    = pick_any_s;
    sel_onehot_s = pick_onehot_s;
    sel_idx_s    = pick_idx_s;
    if (hold_s) begin
      sel_any_s    = 1'b1;
      sel_onehot_s = ONE_HOT0 << o_id_r;
      sel_idx_s    = o_id_r;
    end else begin
      sel_any_s = pick_any_s;
    end
  end
`else
  assign lock_honor_s = 1'b0;
  assign sel_any_s    = pick_any_s;
  assign sel_onehot_s = pick_onehot_s;
  assign sel_idx_s    = pick_idx_s;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sel_any_s) state_nxt_s = EXEC;
        else           state_nxt_s = IDLE;
      end
      EXEC: begin
        if (cnt_r == {CNT_W{1'b0}}) state_nxt_s = RESP;
        else                        state_nxt_s = EXEC;
      end
      RESP: begin
        if (hs_s) state_nxt_s = IDLE;
        else      state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode: next values of the grant, datapath and result flops.
  always_comb begin
    ptr_nxt_s     = ptr_r;
    cnt_nxt_s     = cnt_r;
    a_nxt_s       = a_r;
    b_nxt_s       = b_r;
    gnt_nxt_s     = {N_REQ{1'b0}};
    o_valid_nxt_s = o_valid_r;
    y_nxt_s       = y_r;
    o_id_nxt_s    = o_id_r;
    case (state_r)
      IDLE: begin
        if (sel_any_s) begin
          gnt_nxt_s  = sel_onehot_s;
          a_nxt_s    = bus.i0[sel_idx_s];
          b_nxt_s    = bus.i1[sel_idx_s];
          o_id_nxt_s = sel_idx_s;
          cnt_nxt_s  = CNT_INIT;
        end else begin
          gnt_nxt_s = {N_REQ{1'b0}};
        end
      end
      EXEC: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          y_nxt_s       = gate_op(OP_SEL, a_r, b_r);
          o_valid_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - {{(CNT_W - 1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        if (hs_s) begin
          o_valid_nxt_s = 1'b0;
          // Priority moves past the owner unless it keeps it through LOCK.
          if (lock_honor_s)           ptr_nxt_s = ptr_r;
          else if (o_id_r == LAST_ID) ptr_nxt_s = {ID_W{1'b0}};
          else                        ptr_nxt_s = o_id_r + {{(ID_W - 1){1'b0}}, 1'b1};
        end else begin
          o_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        o_valid_nxt_s = 1'b0;
        gnt_nxt_s     = {N_REQ{1'b0}};
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r     <= {ID_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      a_r       <= 1'b0;
      b_r       <= 1'b0;
      gnt_r     <= {N_REQ{1'b0}};
      busy_r    <= 1'b0;
      o_valid_r <= 1'b0;
      y_r       <= 1'b0;
      o_id_r    <= {ID_W{1'b0}};
    end else begin
      ptr_r     <= ptr_nxt_s;
      cnt_r     <= cnt_nxt_s;
      a_r       <= a_nxt_s;
      b_r       <= b_nxt_s;
      gnt_r     <= gnt_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
      o_valid_r <= o_valid_nxt_s;
      y_r       <= y_nxt_s;
      o_id_r    <= o_id_nxt_s;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.busy    = busy_r;
  assign bus.o_valid = o_valid_r;
  assign bus.y       = y_r;
  assign bus.o_id    = o_id_r;

endmodule
